// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU, the result FIFO and the writeback consumer.
// ALU_RESFIFO_OPCODE_EN adds the in_opcode/out_opcode fields.
interface alu_result_fifo_if #(
   parameter int WIDTH = 8
`ifdef ALU_RESFIFO_OPCODE_EN
   ,
   parameter int OPW = 3
`endif
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_y;
   logic             in_carry;
   logic             in_zero;
   logic             in_overflow;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_y;
   logic             out_carry;
   logic             out_zero;
   logic             out_overflow;

`ifdef ALU_RESFIFO_OPCODE_EN
   logic [OPW-1:0]   in_opcode;
   logic [OPW-1:0]   out_opcode;

   // master: the producer/consumer environment; slave: the FIFO itself
   modport master (
      output in_valid, in_y, in_carry, in_zero, in_overflow, in_opcode, out_ready,
      input  in_ready, out_valid, out_y, out_carry, out_zero, out_overflow, out_opcode
   );

   modport slave (
      input  in_valid, in_y, in_carry, in_zero, in_overflow, in_opcode, out_ready,
      output in_ready, out_valid, out_y, out_carry, out_zero, out_overflow, out_opcode
   );
`else
   modport master (
      output in_valid, in_y, in_carry, in_zero, in_overflow, out_ready,
      input  in_ready, out_valid, out_y, out_carry, out_zero, out_overflow
   );

   modport slave (
      input  in_valid, in_y, in_carry, in_zero, in_overflow, out_ready,
      output in_ready, out_valid, out_y, out_carry, out_zero, out_overflow
   );
`endif

endinterface

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO for ALU result words with sticky carry/overflow status.
// Define ALU_RESFIFO_OPCODE_EN to also carry the producing opcode with each entry.
module alu_result_fifo #(
   parameter int WIDTH      = 8,
   parameter int OPW        = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   alu_result_fifo_if.slave              bus,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          full,
   output logic                          empty,
   input  logic                          sticky_clr,
   output logic                          sticky_carry,
   output logic                          sticky_overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Elaboration-time guard: pointer wrap relies on a power-of-two depth.
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || OPW < 1 || WIDTH < 1)
   begin : g_bad_params
      $error("alu_result_fifo: FIFO_DEPTH must be a power of two >= 2, OPW and WIDTH >= 1");
   end

   typedef struct packed {
`ifdef ALU_RESFIFO_OPCODE_EN
      logic [OPW-1:0]   opcode;
`endif
      logic [WIDTH-1:0] y;
      logic             carry;
      logic             zero;
      logic             overflow;
   } entry_t;

   entry_t           mem_q [FIFO_DEPTH];
   entry_t           mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             sticky_carry_q, sticky_carry_d;
   logic             sticky_overflow_q, sticky_overflow_d;

   logic   full_w;
   logic   empty_w;
   logic   push;
   logic   pop;
   entry_t entry_in;
   entry_t head;

   assign full_w  = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty_w = (count_q == '0);

   // in_ready never looks at out_ready, so a full FIFO refuses a push even while popping.
   assign push = bus.in_valid && !full_w;
   assign pop  = bus.out_ready && !empty_w;

   always_comb begin
      entry_in          = '0;
      entry_in.y        = bus.in_y;
      entry_in.carry    = bus.in_carry;
      entry_in.zero     = bus.in_zero;
      entry_in.overflow = bus.in_overflow;
`ifdef ALU_RESFIFO_OPCODE_EN
      entry_in.opcode   = bus.in_opcode;
`endif
   end

   always_comb begin
      mem_d             = mem_q;
      wr_ptr_d          = wr_ptr_q;
      rd_ptr_d          = rd_ptr_q;
      count_d           = count_q;
      sticky_carry_d    = sticky_clr ? 1'b0 : sticky_carry_q;
      sticky_overflow_d = sticky_clr ? 1'b0 : sticky_overflow_q;

      if (push) begin
         mem_d[wr_ptr_q]   = entry_in;
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
         sticky_carry_d    = sticky_carry_d | bus.in_carry;
         sticky_overflow_d = sticky_overflow_d | bus.in_overflow;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage is left untouched by reset; count==0 already hides stale entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q          <= '0;
         rd_ptr_q          <= '0;
         count_q           <= '0;
         sticky_carry_q    <= 1'b0;
         sticky_overflow_q <= 1'b0;
      end else begin
         mem_q             <= mem_d;
         wr_ptr_q          <= wr_ptr_d;
         rd_ptr_q          <= rd_ptr_d;
         count_q           <= count_d;
         sticky_carry_q    <= sticky_carry_d;
         sticky_overflow_q <= sticky_overflow_d;
      end
   end

   assign head = mem_q[rd_ptr_q];

   assign bus.in_ready     = !full_w;
   assign bus.out_valid    = !empty_w;
   assign bus.out_y        = empty_w ? '0 : head.y;
   assign bus.out_carry    = !empty_w && head.carry;
   assign bus.out_zero     = !empty_w && head.zero;
   assign bus.out_overflow = !empty_w && head.overflow;
`ifdef ALU_RESFIFO_OPCODE_EN
   assign bus.out_opcode   = empty_w ? '0 : head.opcode;
`endif

   assign count           = count_q;
   assign full            = full_w;
   assign empty           = empty_w;
   assign sticky_carry    = sticky_carry_q;
   assign sticky_overflow = sticky_overflow_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: directed vector table, hand sequences, and
// randomized traffic against a queue-based reference model.
module tb_alu_result_fifo;

   localparam int WIDTH = 8;
   localparam int OPW   = 3;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] count;
   logic       full;
   logic       empty;
   logic       sticky_clr;
   logic       sticky_carry;
   logic       sticky_overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

`ifdef ALU_RESFIFO_OPCODE_EN
   alu_result_fifo_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();
`else
   alu_result_fifo_if #(.WIDTH(WIDTH)) bus ();
`endif

   alu_result_fifo #(.WIDTH(WIDTH), .OPW(OPW), .FIFO_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .count           (count),
      .full            (full),
      .empty           (empty),
      .sticky_clr      (sticky_clr),
      .sticky_carry    (sticky_carry),
      .sticky_overflow (sticky_overflow)
   );

   // Reference model: a queue of accepted words plus two sticky bits.
   typedef struct {
      logic [7:0] y;
      logic       c;
      logic       z;
      logic       o;
      logic [2:0] op;
   } ent_t;

   ent_t mq[$];
   logic m_sc = 1'b0;
   logic m_so = 1'b0;

   // Directed vector: inputs for one cycle and the expected state after the edge.
   typedef struct {
      logic       v;
      logic [7:0] y;
      logic [2:0] f;
      logic       r;
      logic       clr;
      logic [2:0] e_cnt;
      logic       e_val;
      logic [7:0] e_y;
      logic [2:0] e_f;
      logic       e_full;
      logic       e_sc;
      logic       e_so;
   } vec_t;

   vec_t vt[$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] y, input logic c, input logic z,
                                input logic o, input logic [2:0] op, input logic r,
                                input logic clr, input logic rs);
      bit   do_push;
      bit   do_pop;
      ent_t e;
      bus.in_valid    = v;
      bus.in_y        = y;
      bus.in_carry    = c;
      bus.in_zero     = z;
      bus.in_overflow = o;
`ifdef ALU_RESFIFO_OPCODE_EN
      bus.in_opcode   = op;
`endif
      bus.out_ready   = r;
      sticky_clr      = clr;
      rst             = rs;
      @(posedge clk);
      do_push = v && (mq.size() < DEPTH);
      do_pop  = r && (mq.size() > 0);
      e.y = y; e.c = c; e.z = z; e.o = o; e.op = op;
      if (rs) begin
         mq.delete();
         m_sc = 1'b0;
         m_so = 1'b0;
      end else begin
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back(e);
         m_sc = (clr ? 1'b0 : m_sc) | (do_push && c);
         m_so = (clr ? 1'b0 : m_so) | (do_push && o);
      end
      #1;
   endtask

   task automatic checkModel(input string tag);
      int         n;
      logic [7:0] ey;
      logic [2:0] ef;
      n  = mq.size();
      ey = (n > 0) ? mq[0].y : 8'h00;
      ef = (n > 0) ? {mq[0].c, mq[0].z, mq[0].o} : 3'b000;
      checkOutput({tag, "_count"}, 32'(count), 32'(n));
      checkOutput({tag, "_empty"}, 32'(empty), 32'(n == 0));
      checkOutput({tag, "_full"}, 32'(full), 32'(n == DEPTH));
      checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'(n != DEPTH));
      checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 32'(n != 0));
      checkOutput({tag, "_out_y"}, 32'(bus.out_y), 32'(ey));
      checkOutput({tag, "_flags"}, 32'({bus.out_carry, bus.out_zero, bus.out_overflow}), 32'(ef));
      checkOutput({tag, "_sticky"}, 32'({sticky_carry, sticky_overflow}), 32'({m_sc, m_so}));
`ifdef ALU_RESFIFO_OPCODE_EN
      checkOutput({tag, "_opcode"}, 32'(bus.out_opcode), 32'((n > 0) ? mq[0].op : 3'b000));
`endif
   endtask

   initial begin
      vt.push_back('{1'b1, 8'h2A, 3'b000, 1'b0, 1'b0, 3'd1, 1'b1, 8'h2A, 3'b000, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 8'h01, 3'b000, 1'b0, 1'b0, 3'd1, 1'b1, 8'h01, 3'b000, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 8'h02, 3'b000, 1'b0, 1'b0, 3'd2, 1'b1, 8'h01, 3'b000, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 8'h03, 3'b000, 1'b0, 1'b0, 3'd3, 1'b1, 8'h01, 3'b000, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 8'h04, 3'b000, 1'b0, 1'b0, 3'd4, 1'b1, 8'h01, 3'b000, 1'b1, 1'b0, 1'b0});
      vt.push_back('{1'b1, 8'h05, 3'b000, 1'b0, 1'b0, 3'd4, 1'b1, 8'h01, 3'b000, 1'b1, 1'b0, 1'b0});
      vt.push_back('{1'b1, 8'h05, 3'b000, 1'b1, 1'b0, 3'd3, 1'b1, 8'h02, 3'b000, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 3'd2, 1'b1, 8'h03, 3'b000, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 3'd1, 1'b1, 8'h04, 3'b000, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 8'h06, 3'b000, 1'b1, 1'b0, 3'd1, 1'b1, 8'h06, 3'b000, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 8'h00, 3'b110, 1'b0, 1'b0, 3'd1, 1'b1, 8'h00, 3'b110, 1'b0, 1'b1, 1'b0});
      vt.push_back('{1'b1, 8'h11, 3'b000, 1'b0, 1'b0, 3'd2, 1'b1, 8'h00, 3'b110, 1'b0, 1'b1, 1'b0});
      vt.push_back('{1'b0, 8'h00, 3'b000, 1'b1, 1'b1, 3'd1, 1'b1, 8'h11, 3'b000, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 8'h22, 3'b001, 1'b1, 1'b1, 3'd1, 1'b1, 8'h22, 3'b001, 1'b0, 1'b0, 1'b1});
      vt.push_back('{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1});
      vt.push_back('{1'b1, 8'h33, 3'b100, 1'b0, 1'b1, 3'd1, 1'b1, 8'h33, 3'b100, 1'b0, 1'b1, 1'b0});
      vt.push_back('{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0});

      // Reset then idle
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("reset_count", 32'(count), 32'd0);
      checkOutput("reset_empty", 32'(empty), 32'd1);
      checkOutput("reset_full", 32'(full), 32'd0);
      checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset_out_y", 32'(bus.out_y), 32'd0);
      checkOutput("reset_sticky", 32'({sticky_carry, sticky_overflow}), 32'd0);

      // Directed table; opcode mirrors y[2:0] so the expected head opcode is e_y[2:0]
      for (int i = 0; i < vt.size(); i++) begin
         string t;
         t = $sformatf("vec%0d", i);
         applyStimulus(vt[i].v, vt[i].y, vt[i].f[2], vt[i].f[1], vt[i].f[0], vt[i].y[2:0],
                       vt[i].r, vt[i].clr, 1'b0);
         checkOutput({t, "_count"}, 32'(count), 32'(vt[i].e_cnt));
         checkOutput({t, "_out_valid"}, 32'(bus.out_valid), 32'(vt[i].e_val));
         checkOutput({t, "_empty"}, 32'(empty), 32'(!vt[i].e_val));
         checkOutput({t, "_out_y"}, 32'(bus.out_y), 32'(vt[i].e_y));
         checkOutput({t, "_flags"}, 32'({bus.out_carry, bus.out_zero, bus.out_overflow}),
                     32'(vt[i].e_f));
         checkOutput({t, "_full"}, 32'(full), 32'(vt[i].e_full));
         checkOutput({t, "_in_ready"}, 32'(bus.in_ready), 32'(!vt[i].e_full));
         checkOutput({t, "_sticky"}, 32'({sticky_carry, sticky_overflow}),
                     32'({vt[i].e_sc, vt[i].e_so}));
`ifdef ALU_RESFIFO_OPCODE_EN
         checkOutput({t, "_opcode"}, 32'(bus.out_opcode), 32'(vt[i].e_y[2:0]));
`endif
      end

      // Steady push+pop at occupancy 2; pointers wrap several times
      applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 8'(8'h12 + i), 1'b0, 1'b0, 1'b0, 3'(i), 1'b1, 1'b0, 1'b0);
         checkOutput($sformatf("steady%0d_count", i), 32'(count), 32'd2);
         checkOutput($sformatf("steady%0d_out_y", i), 32'(bus.out_y), 32'(8'h11 + i));
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
      checkModel("steady_drain");

      // Reset at count=3 with push+pop in flight
      applyStimulus(1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
      checkOutput("prerst_count", 32'(count), 32'd3);
      checkOutput("prerst_sticky", 32'({sticky_carry, sticky_overflow}), 32'd3);
      applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1);
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_empty", 32'(empty), 32'd1);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_out_y", 32'(bus.out_y), 32'd0);
      checkOutput("rst_sticky", 32'({sticky_carry, sticky_overflow}), 32'd0);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef ALU_RESFIFO_OPCODE_EN
      applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0);
      checkOutput("op101_opcode", 32'(bus.out_opcode), 32'(3'b101));
      checkOutput("op101_out_y", 32'(bus.out_y), 32'h5A);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("op101_drained_opcode", 32'(bus.out_opcode), 32'd0);
`endif

      // Randomized traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         logic [31:0] rv;
         rv = $urandom;
         applyStimulus(rv[0] | rv[1], 8'($urandom), rv[2], rv[3], rv[4], 3'($urandom),
                       rv[5] | (rv[6] & rv[7]), (rv[15:11] == 5'd0), (rv[23:18] == 6'd0));
         checkModel($sformatf("rand%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
